// File: rtl/chorus_filter_gen2_if.sv
// rtl/chorus_filter_gen2_if.sv - sample strobe, data and status bundle for chorus_filter_gen2
interface chorus_filter_gen2_if #(
    parameter int DATA_W = 16
);
    logic              enable;
    logic [DATA_W-1:0] dataIn;
    logic [DATA_W-1:0] dataOut;
    logic              dataValid;
    logic              busy;
    logic              overrun;

    modport master (
        output enable,
        output dataIn,
        input  dataOut,
        input  dataValid,
        input  busy,
        input  overrun
    );

    modport slave (
        input  enable,
        input  dataIn,
        output dataOut,
        output dataValid,
        output busy,
        output overrun
    );
endinterface

// File: rtl/chorus_filter_gen2.sv
// rtl/chorus_filter_gen2.sv - sample-strobed chorus: circular delay line, triangle-LFO tap, dry/wet average
// Define CHORUS_INTERP_EN for two-tap linear fractional-delay interpolation.
module chorus_filter_gen2 #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int MIN_DELAY = 64,
    parameter int SWEEP_W   = 8,
    parameter int FRAC_W    = 8,
    parameter int LFO_STEP  = 1
) (
    input  logic                clk,
    input  logic                resetn,
    chorus_filter_gen2_if.slave bus
);
    localparam int PH_W   = SWEEP_W + FRAC_W + 1;
    localparam int PROD_W = DATA_W + FRAC_W + 2;

`ifdef CHORUS_INTERP_EN
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, WAIT_B, INTERP, WET, MIX} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD_A, WAIT_A, WET, MIX} state_t;
`endif

    state_t                   r_state, w_next;
    logic [ADDR_W-1:0]        r_wr_ptr;
    logic [PH_W-1:0]          r_phase;
    logic [ADDR_W:0]          r_fill;
    logic signed [DATA_W-1:0] r_dry, r_tap_a, r_wet, r_data_out, r_rd_data;
    logic                     r_valid, r_overrun;
    logic [DATA_W-1:0]        r_mem [0:(1<<ADDR_W)-1];

    logic [SWEEP_W-1:0]       w_tri_top;
    logic [ADDR_W-1:0]        w_delay, w_rd_addr;
    logic                     w_warm;
    logic signed [DATA_W-1:0] w_wet_calc;
    logic signed [DATA_W:0]   w_sum;

    // Only the sweep bits of the folded triangle select the integer delay.
    assign w_tri_top = r_phase[PH_W-1] ? ~r_phase[PH_W-2 -: SWEEP_W] : r_phase[PH_W-2 -: SWEEP_W];
    assign w_delay   = ADDR_W'(MIN_DELAY) + ADDR_W'(w_tri_top);

`ifdef CHORUS_INTERP_EN
    logic signed [DATA_W-1:0] r_tap_b;
    logic signed [PROD_W-1:0] r_prod;
    logic [FRAC_W-1:0]        w_frac;
    logic signed [DATA_W:0]   w_diff;
    logic signed [PROD_W-1:0] w_diff_x, w_frac_x;

    assign w_frac = r_phase[PH_W-1] ? ~r_phase[FRAC_W-1:0] : r_phase[FRAC_W-1:0];
    assign w_diff = {r_tap_b[DATA_W-1], r_tap_b} - {r_tap_a[DATA_W-1], r_tap_a};
    assign w_diff_x = {{(FRAC_W+1){w_diff[DATA_W]}}, w_diff};
    assign w_frac_x = {{(DATA_W+2){1'b0}}, w_frac};
    assign w_rd_addr = (r_state == RD_B) ? (r_wr_ptr - w_delay - ADDR_W'(1)) : (r_wr_ptr - w_delay);
    assign w_wet_calc = DATA_W'({{(FRAC_W+2){r_tap_a[DATA_W-1]}}, r_tap_a} + (r_prod >>> FRAC_W));
    // fill counts finished samples; the current one is already in RAM, so tap B needs fill >= D+1.
    assign w_warm = r_fill > {1'b0, w_delay};
`else
    assign w_rd_addr  = r_wr_ptr - w_delay;
    assign w_wet_calc = r_tap_a;
    assign w_warm     = r_fill >= {1'b0, w_delay};
`endif

    assign w_sum         = {r_dry[DATA_W-1], r_dry} + {r_wet[DATA_W-1], r_wet};
    assign bus.dataOut   = r_data_out;
    assign bus.dataValid = r_valid;
    assign bus.busy      = (r_state != IDLE);
    assign bus.overrun   = r_overrun;

    always_ff @(posedge clk) begin
        if (r_state == RD_A) r_mem[r_wr_ptr] <= r_dry;
        r_rd_data <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (bus.enable) w_next = RD_A;
`ifdef CHORUS_INTERP_EN
            RD_A:   w_next = RD_B;
            RD_B:   w_next = WAIT_B;
            WAIT_B: w_next = INTERP;
            INTERP: w_next = WET;
`else
            RD_A:   w_next = WAIT_A;
            WAIT_A: w_next = WET;
`endif
            WET:    w_next = MIX;
            MIX:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_phase    <= '0;
            r_fill     <= '0;
            r_dry      <= '0;
            r_tap_a    <= '0;
            r_wet      <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
`ifdef CHORUS_INTERP_EN
            r_tap_b    <= '0;
            r_prod     <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            if (bus.enable && r_state != IDLE) r_overrun <= 1'b1;
            case (r_state)
                IDLE:   if (bus.enable) r_dry <= bus.dataIn;
`ifdef CHORUS_INTERP_EN
                RD_B:   r_tap_a <= r_rd_data;
                WAIT_B: r_tap_b <= r_rd_data;
                INTERP: r_prod  <= w_diff_x * w_frac_x;
`else
                WAIT_A: r_tap_a <= r_rd_data;
`endif
                WET:    r_wet <= w_warm ? w_wet_calc : '0;
                MIX: begin
                    r_data_out <= DATA_W'(w_sum >>> 1);
                    r_valid    <= 1'b1;
                    r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
                    r_phase    <= r_phase + PH_W'(LFO_STEP);
                    if (!r_fill[ADDR_W]) r_fill <= r_fill + (ADDR_W+1)'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
